// File: rtl/dd_pkg.sv
// Shared widths and FSM state type for the DD PUF response serializer.
// The PAR state only exists when DD_RESP_PARITY_EN is defined.
package dd_pkg;

  localparam int RESP_W = 128;
  localparam int BYTE_W = 8;
  localparam int NBYTES = 16;
  localparam int IDX_W  = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

`ifdef DD_RESP_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAR  = 2'd2
  } dd_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } dd_state_e;
`endif

endpackage

// File: rtl/dd_rise_det.sv
// Registered rising-edge detector; the delayed copy resets to RST_VAL
// so a level already high at reset release is not seen as an edge.
module dd_rise_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_d,
  output logic o_rise
);

  logic r_d;

  always_ff @(posedge CLK) begin
    if (RESET) r_d <= RST_VAL;
    else       r_d <= i_d;
  end

  assign o_rise = i_d & ~r_d;

endmodule

// File: rtl/dd_resp_serializer.sv
// Serializes a 128-bit DD PUF response into bytes over a valid/ready port.
// Define DD_RESP_PARITY_EN to append an XOR parity byte after byte 15.
module dd_resp_serializer
  import dd_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DONE_IN,
  input  logic [RESP_W-1:0] RESP_IN,
  input  logic              TX_READY,
  input  logic              CLR_OVR,
  output logic [BYTE_W-1:0] TX_DATA,
  output logic              TX_VALID,
  output logic              BUSY,
  output logic              OVERRUN
);

  logic              w_rise;
  logic              w_xfer;
  logic [IDX_W-1:0]  w_sel;
  logic [BYTE_W-1:0] w_byte;

  dd_state_e         r_state;
  logic [RESP_W-1:0] r_sr;
  logic [IDX_W-1:0]  r_idx;
  logic              r_ovr;
`ifdef DD_RESP_PARITY_EN
  logic [BYTE_W-1:0] r_par;
`endif

  dd_rise_det #(
    .RST_VAL (1'b1)
  ) u_rise (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_d    (DONE_IN),
    .o_rise (w_rise)
  );

  // MSB-first walks from the top byte down: 15 - idx == ~idx.
  assign w_sel  = MSB_FIRST ? ~r_idx : r_idx;
  assign w_byte = r_sr[w_sel*BYTE_W +: BYTE_W];

  assign BUSY     = (r_state != ST_IDLE);
  assign TX_VALID = BUSY;
  assign w_xfer   = TX_VALID & TX_READY;
  assign OVERRUN  = r_ovr;

  always_comb begin
    TX_DATA = '0;
    unique case (r_state)
      ST_SEND: TX_DATA = w_byte;
`ifdef DD_RESP_PARITY_EN
      ST_PAR:  TX_DATA = r_par;
`endif
      default: TX_DATA = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_idx   <= '0;
      r_ovr   <= 1'b0;
`ifdef DD_RESP_PARITY_EN
      r_par   <= '0;
`endif
    end else begin
      // Set beats clear when both land together.
      r_ovr <= (w_rise & BUSY) | (r_ovr & ~CLR_OVR);
      unique case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_sr    <= RESP_IN;
            r_idx   <= '0;
            r_state <= ST_SEND;
`ifdef DD_RESP_PARITY_EN
            r_par   <= '0;
`endif
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_idx <= r_idx + 1'b1;
`ifdef DD_RESP_PARITY_EN
            r_par <= r_par ^ w_byte;
`endif
            if (r_idx == LAST_IDX) begin
`ifdef DD_RESP_PARITY_EN
              r_state <= ST_PAR;
`else
              r_state <= ST_IDLE;
`endif
            end
          end
        end
`ifdef DD_RESP_PARITY_EN
        ST_PAR: begin
          if (w_xfer) r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dd_resp_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share stimulus;
// expected bytes are queued at issue and popped by per-instance monitors.
module tb_dd_resp_serializer;

`ifdef DD_RESP_PARITY_EN
  localparam int WB = 17;
`else
  localparam int WB = 16;
`endif

  localparam logic [127:0] W1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] W2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] W3 = 128'h1;

  logic         clk;
  logic         rst;
  logic         done_in;
  logic [127:0] resp_in;
  logic         tx_ready;
  logic         clr_ovr;

  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic       m_busy, l_busy;
  logic       m_ovr, l_ovr;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_xm   = 0;
  int n_xl   = 0;

  logic       m_stall_p = 1'b0;
  logic       l_stall_p = 1'b0;
  logic [7:0] m_last = '0;
  logic [7:0] l_last = '0;

  dd_resp_serializer #(.MSB_FIRST(1'b1)) dut_m (
    .CLK      (clk),
    .RESET    (rst),
    .DONE_IN  (done_in),
    .RESP_IN  (resp_in),
    .TX_READY (tx_ready),
    .CLR_OVR  (clr_ovr),
    .TX_DATA  (m_data),
    .TX_VALID (m_valid),
    .BUSY     (m_busy),
    .OVERRUN  (m_ovr)
  );

  dd_resp_serializer #(.MSB_FIRST(1'b0)) dut_l (
    .CLK      (clk),
    .RESET    (rst),
    .DONE_IN  (done_in),
    .RESP_IN  (resp_in),
    .TX_READY (tx_ready),
    .CLR_OVR  (clr_ovr),
    .TX_DATA  (l_data),
    .TX_VALID (l_valid),
    .BUSY     (l_busy),
    .OVERRUN  (l_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [127:0] w, input logic [7:0] par);
    for (int i = 0; i < 16; i++) begin
      q_m.push_back(w[(15-i)*8 +: 8]);
      q_l.push_back(w[i*8 +: 8]);
    end
`ifdef DD_RESP_PARITY_EN
    q_m.push_back(par);
    q_l.push_back(par);
`else
    if (par === 8'hxx) $display("parity arg unknown");
`endif
  endtask

  task automatic start_word(input logic [127:0] w, input logic [7:0] par);
    resp_in = w;
    push_word(w, par);
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (!m_busy && !l_busy && q_m.size() == 0 && q_l.size() == 0) break;
      tick();
    end
    chk({nm, "_drain"},
        {6'd0, m_busy | l_busy, (q_m.size() != 0) | (q_l.size() != 0)},
        8'h00);
  endtask

  always @(negedge clk) begin
    if (m_stall_p && m_valid) chk("hold_m", m_data, m_last);
    if (m_valid && tx_ready) begin
      n_xm++;
      if (q_m.size() == 0) chk("extra_byte_m", m_data, 8'hxx);
      else chk("byte_m", m_data, q_m.pop_front());
    end
    m_stall_p = m_valid && !tx_ready;
    m_last    = m_data;
  end

  always @(negedge clk) begin
    if (l_stall_p && l_valid) chk("hold_l", l_data, l_last);
    if (l_valid && tx_ready) begin
      n_xl++;
      if (q_l.size() == 0) chk("extra_byte_l", l_data, 8'hxx);
      else chk("byte_l", l_data, q_l.pop_front());
    end
    l_stall_p = l_valid && !tx_ready;
    l_last    = l_data;
  end

  initial begin
    int xm0;
    int xl0;
    rst      = 1'b1;
    done_in  = 1'b0;
    resp_in  = '0;
    tx_ready = 1'b0;
    clr_ovr  = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {6'd0, m_valid, l_valid}, 8'h00);
    chk("rst_data_m", m_data, 8'h00);
    chk("rst_data_l", l_data, 8'h00);
    chk("rst_busy", {6'd0, m_busy, l_busy}, 8'h00);
    chk("rst_ovr", {6'd0, m_ovr, l_ovr}, 8'h00);
    rst = 1'b0;
    tick();

    // Full word at one byte per cycle
    tx_ready = 1'b1;
    start_word(W1, 8'h00);
    repeat (WB - 1) tick();
    chk("busy_last", {6'd0, m_busy, l_busy}, 8'h03);
    tick();
    chk("idle_after", {6'd0, m_busy, l_busy}, 8'h00);
    chk("idle_data_m", m_data, 8'h00);
    wait_idle("w1");

    // Stall pattern 1,0,0,1
    xm0 = n_xm;
    xl0 = n_xl;
    start_word(W2, 8'h00);
    for (int i = 0; i < 200 && m_busy; i++) begin
      tx_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("stall");
    chk("stall_cnt_m", 8'(n_xm - xm0), 8'(WB));
    chk("stall_cnt_l", 8'(n_xl - xl0), 8'(WB));

    // Overrun at byte 5, new word discarded
    start_word(W1, 8'h00);
    repeat (5) tick();
    resp_in = '1;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("ovr_set", {6'd0, m_ovr, l_ovr}, 8'h03);
    wait_idle("ovr");
    chk("ovr_sticky", {6'd0, m_ovr, l_ovr}, 8'h03);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr", {6'd0, m_ovr, l_ovr}, 8'h00);

    // Clear and set in the same cycle: set wins
    start_word(W1, 8'h00);
    repeat (3) tick();
    done_in = 1'b1;
    clr_ovr = 1'b1;
    tick();
    done_in = 1'b0;
    clr_ovr = 1'b0;
    chk("ovr_setwins", {6'd0, m_ovr, l_ovr}, 8'h03);
    wait_idle("setwins");
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;

    // Rise on the final-byte transfer cycle
    start_word(W3, 8'h01);
    repeat (15) tick();
    resp_in = W2;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    chk("ovr_last", {6'd0, m_ovr, l_ovr}, 8'h03);
    wait_idle("last");
    repeat (3) tick();
    chk("no_capture", {6'd0, m_busy, l_busy}, 8'h00);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;

    // Reset at byte 8 with DONE_IN held high through release
    start_word(W1, 8'h00);
    repeat (8) tick();
    tx_ready = 1'b0;
    rst      = 1'b1;
    done_in  = 1'b1;
    q_m.delete();
    q_l.delete();
    tick();
    tick();
    chk("abort_valid", {6'd0, m_valid, l_valid}, 8'h00);
    rst      = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_no_cap", {4'd0, m_valid, l_valid, m_busy, l_busy}, 8'h00);
    end
    done_in = 1'b0;
    tick();
    start_word(W3, 8'h01);
    chk("recapture", {6'd0, m_busy, l_busy}, 8'h03);
    wait_idle("recap");

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dd_resp_serializer.md
DD_RESP_SERIALIZER -- requirements
Module: dd_resp_serializer

Interface
REQ-001 Parameter MSB_FIRST, default 1; 1 sends byte RESP[127:120] first, 0 sends RESP[7:0] first.
REQ-002 CLK  input  1  clock; all logic on rising edge.
REQ-003 RESET  input  1  reset: synchronous, active-high.
REQ-004 DONE_IN  input  1  sample-complete strobe from DD PUF controller; rising edge marks RESP_IN valid.
REQ-005 RESP_IN  input  128  captured PUF response word.
REQ-006 TX_READY  input  1  downstream (SPI TX) accepts byte this cycle.
REQ-007 CLR_OVR  input  1  clears OVERRUN.
REQ-008 TX_DATA  output  8  current response byte.
REQ-009 TX_VALID  output  1  TX_DATA valid.
REQ-010 BUSY  output  1  high in any state other than IDLE.
REQ-011 OVERRUN  output  1  sticky: DONE_IN rising edge arrived while BUSY.

Function
REQ-012 Rising edge detection shall be registered: DONE_D <= DONE_IN; rise = DONE_IN & ~DONE_D.
REQ-013 States shall be IDLE, SEND, PAR (PAR exists only with DD_RESP_PARITY_EN).
REQ-014 In IDLE, a rise at clock edge k shall load RESP_IN into the 128-bit shift register, clear the byte index to 0, and enter SEND; TX_VALID shall be high from edge k+1.
REQ-015 In SEND, TX_VALID shall be 1 and TX_DATA shall be the byte selected by the byte index and MSB_FIRST.
REQ-016 A byte transfers on an edge with TX_VALID & TX_READY; the byte index then increments by 1.
REQ-017 TX_DATA shall be held stable while TX_VALID & ~TX_READY.
REQ-018 A transfer of byte index 15 shall go to IDLE (no parity) or PAR (parity); the index is 4 bits and shall not wrap during SEND.
REQ-019 Back-to-back transfers shall sustain 1 byte/cycle; a full word takes 16 cycles with TX_READY held at 1.
REQ-020 A rise outside IDLE, including the final-byte transfer cycle, shall discard RESP_IN, leave the shift register unchanged, and set OVERRUN on the next edge.
REQ-021 OVERRUN shall clear on CLR_OVR; when a set event and CLR_OVR occur in the same cycle, set wins.
REQ-022 TX_VALID shall be 0 in IDLE; TX_DATA in IDLE shall be 8'h00.

Reset
REQ-023 RESET shall take priority over all inputs: state IDLE, shift register 0, byte index 0, TX_VALID 0, TX_DATA 8'h00, BUSY 0, OVERRUN 0, parity accumulator 0.
REQ-024 DONE_D shall reset to 1, so a DONE_IN held high through reset release does not trigger a capture.
REQ-025 RESET asserted mid-word shall abort the word; no further bytes are presented for it.

Configuration
REQ-026 Macro DD_RESP_PARITY_EN defined: after byte 15, state PAR presents the XOR of all 16 bytes with TX_VALID=1 under the same handshake, then returns to IDLE; a word is 17 bytes.
REQ-027 Macro DD_RESP_PARITY_EN undefined: no PAR state and no accumulator; a word is 16 bytes.

Structure
REQ-028 Shared package dd_pkg shall hold RESP_W=128, BYTE_W=8, NBYTES=16, and the state enumeration type.
REQ-029 One sub-module, dd_rise_det (registered rising-edge detector with reset value input), shall be instantiated for DONE_IN.
REQ-030 The serializer FSM, shift register, index and OVERRUN logic shall reside in the top module.

Verification
REQ-031 RESP_IN=128'h00112233_44556677_8899AABB_CCDDEEFF, DONE_IN pulse, TX_READY=1, MSB_FIRST=1 -> bytes 00,11,...,FF on 16 consecutive cycles, then BUSY=0.
REQ-032 Same word, MSB_FIRST=0 -> first byte FF, last byte 00.
REQ-033 TX_READY toggling 1,0,0,1,... -> TX_DATA held during stalls; no byte lost or duplicated; 16 transfers total.
REQ-034 Second DONE_IN rise at byte 5 with RESP_IN=all-ones -> OVERRUN=1, remaining bytes from the first word; CLR_OVR together with a new overrun -> OVERRUN stays 1.
REQ-035 RESET pulsed at byte 8 with DONE_IN held high through release -> TX_VALID=0, no capture until DONE_IN goes low then high.
REQ-036 DD_RESP_PARITY_EN defined, word from REQ-031 -> 17th byte 8'h00; with RESP_IN=128'h1 -> 17th byte 8'h01.
